div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- EX-stage sequencer between the decoded DIV/DIVU instruction and the 32-bit iterative divider; owns the architectural HI/LO pair.
- Latches operands, holds the divider's start level, and stalls the pipeline until the divider's done pulse.
- Commits quotient to LO and remainder to HI, honours flush, and arbitrates MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- HILO_RST, 32'h0, reset value of HI and LO.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- div_req  in  1  DIV/DIVU instruction valid in EX
- div_signed  in  1  1 = DIV, 0 = DIVU
- op_a  in  32  dividend (rs)
- op_b  in  32  divisor (rt)
- flush  in  1  EX instruction killed (exception/eret)
- pipe_stall  in  1  pipeline frozen by another source
- stall_req  out  1  hold IF..EX
- div_start  out  1  divider start level
- div_sign  out  1  divider signed-mode select
- div_a  out  32  divider dividend
- div_b  out  32  divider divisor
- div_quotient  in  32  divider quotient
- div_remainder  in  32  divider remainder
- div_done  in  1  divider done pulse, one cycle
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- hilo_wdata  in  32  MTHI/MTLO data
- hi_o  out  32  HI register
- lo_o  out  32  LO register

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - State = IDLE; operand/sign latches = 0; hi_o = lo_o = HILO_RST.
  - stall_req = div_start = 0.
- div_a, div_b and div_sign come from registered latches and stay stable from capture through the done cycle. The divider's outputs depend combinationally on div_sign, so these latches must not change before commit.
- IDLE:
  - div_req && !flush → latch op_a, op_b, div_signed; go to BUSY.
  - stall_req = div_req && !flush, combinational in the same cycle.
  - div_done is ignored in IDLE. A stale pulse after abort must not commit.
- BUSY:
  - div_start = !flush; stall_req = 1.
  - flush → go to IDLE; no HI/LO write. div_start is low this cycle so the divider counter clears.
  - div_done && !flush → lo_o <= div_quotient, hi_o <= div_remainder; go to FINISH.
- FINISH:
  - stall_req = 0; div_start = 0. The divider counter wraps to 0.
  - If pipe_stall = 1, stay in FINISH. div_req is still high for the same instruction, so the division must not restart.
  - If pipe_stall = 0, go to IDLE.
  - flush in FINISH → go to IDLE. The commit already happened and stands.
- Latency: divider loads on the first BUSY cycle, and div_done arrives on the 34th BUSY cycle.
  - Total stall = 35 cycles (request cycle + 34 BUSY).
  - HI/LO are visible on the cycle after done (first FINISH cycle).
- Back-to-back divides: the second request is accepted in IDLE after FINISH. The divider always sees start low for at least one cycle between operations.
- HI/LO write priority, per register: div commit > MTHI/MTLO. The DIV in EX is younger than any mover in MEM/WB.
  - hi_we/lo_we act independently and are accepted in every state.
  - In BUSY without done, a mover write updates the register normally.
- Divide by zero: no detection. Whatever the divider returns is committed, per the architectural "undefined" result.
- rst mid-BUSY → IDLE at the next edge, no commit, div_start low. The divider is reset by the same rst.
- pipe_stall during BUSY has no effect; the divider keeps running.

Decomposition:
- Shared package holds:
  - state encoding DIV_IDLE = 2'd0, DIV_BUSY = 2'd1, DIV_FINISH = 2'd2
  - DIV_LATENCY = 34 (BUSY cycles to done), for the bench
  - HILO_RST constant
- One natural sub-module: hilo_reg, holding the HI/LO registers with the priority write mux. The FSM and operand latches stay in div_ctrl.
- The divider itself is instantiated beside div_ctrl in the EX stage, not inside it.

Test Plan:
- DIVU 100/7, pipe_stall = 0 → stall_req high exactly 35 cycles; LO = 14, HI = 2; div_start high exactly 34 cycles.
- DIV 0xFFFFFFF9 / 2 (−7/2) → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 7 / 0xFFFFFFFE → LO = 0xFFFFFFFD, HI = 1.
- Flush on BUSY cycle 10 → no HI/LO change; stall_req low the next cycle. Then an immediate DIVU 0xFFFFFFFF/16 → LO = 0x0FFFFFFF, HI = 0xF.
- Done, then pipe_stall held 3 cycles with div_req still high → stays in FINISH; div_start stays 0; HI/LO unchanged after the commit.
- lo_we with 0x1234 on the same cycle as done of DIVU 9/4 → LO = 2, HI = 1. lo_we during BUSY (no done) → LO = 0x1234 immediately.
- rst asserted on BUSY cycle 20 → HI = LO = 0, IDLE, stall_req = 0. A fresh DIVU 50/5 afterwards → LO = 10, HI = 0.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the DIV/DIVU sequencer in EX and its HI/LO register pair.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_BUSY   = 2'd1,
        DIV_FINISH = 2'd2
    } div_state_e;

    // BUSY cycles from divider load to its done pulse
    localparam int unsigned DIV_LATENCY = 34;

    localparam logic [31:0] HILO_RST = 32'h0;

endpackage

// File: rtl/div_ctrl_hilo_reg.sv
// Architectural HI/LO pair; a divide commit outranks MTHI/MTLO writes on the same cycle.
import div_ctrl_pkg::*;

module div_ctrl_hilo_reg #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = HILO_RST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit,
    input  logic [WIDTH-1:0] quotient,
    input  logic [WIDTH-1:0] remainder,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // The DIV in EX is younger than any mover further down the pipe, so it wins.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit) begin
            hi_d = remainder;
            lo_d = quotient;
        end else begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= RST_VAL;
            lo_q <= RST_VAL;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/div_ctrl.sv
// EX-stage sequencer for DIV/DIVU: latches operands, drives the external iterative divider,
// stalls the pipe until done and commits quotient/remainder into HI/LO.
import div_ctrl_pkg::*;

module div_ctrl #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] HILO_RST = div_ctrl_pkg::HILO_RST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_req,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             pipe_stall,
    output logic             stall_req,
    output logic             div_start,
    output logic             div_sign,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder,
    input  logic             div_done,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sign_q, sign_d;
    logic             commit;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sign_d    = sign_q;
        stall_req = 1'b0;
        div_start = 1'b0;
        commit    = 1'b0;
        unique case (state_q)
            DIV_IDLE: begin
                // done is ignored here so a stale pulse after an abort never commits
                if (div_req && !flush) begin
                    stall_req = 1'b1;
                    a_d       = op_a;
                    b_d       = op_b;
                    sign_d    = div_signed;
                    state_d   = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                stall_req = 1'b1;
                div_start = !flush;
                if (flush) begin
                    state_d = DIV_IDLE;
                end else if (div_done) begin
                    commit  = 1'b1;
                    state_d = DIV_FINISH;
                end
            end
            DIV_FINISH: begin
                // div_req is still the same instruction while the pipe is frozen
                if (flush || !pipe_stall) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
        end
    end

    assign div_a    = a_q;
    assign div_b    = b_q;
    assign div_sign = sign_q;

    div_ctrl_hilo_reg #(
        .WIDTH  (WIDTH),
        .RST_VAL(HILO_RST)
    ) u_hilo_reg (
        .clk      (clk),
        .rst      (rst),
        .commit   (commit),
        .quotient (div_quotient),
        .remainder(div_remainder),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (hilo_wdata),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural iterative divider beside it.
import div_ctrl_pkg::*;

module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        div_req;
    logic        div_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        pipe_stall;
    logic        stall_req;
    logic        div_start;
    logic        div_sign;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_done;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hilo_wdata;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    logic        done_inj;
    logic [5:0]  dcnt_q;

    int n_vec;
    int n_miss;

    div_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .div_req      (div_req),
        .div_signed   (div_signed),
        .op_a         (op_a),
        .op_b         (op_b),
        .flush        (flush),
        .pipe_stall   (pipe_stall),
        .stall_req    (stall_req),
        .div_start    (div_start),
        .div_sign     (div_sign),
        .div_a        (div_a),
        .div_b        (div_b),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .div_done     (div_done),
        .hi_we        (hi_we),
        .lo_we        (lo_we),
        .hilo_wdata   (hilo_wdata),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: loads on the first start cycle, pulses done on the 34th.
    always_ff @(posedge clk) begin
        if (rst || !div_start) dcnt_q <= '0;
        else                   dcnt_q <= dcnt_q + 6'd1;
    end

    assign div_done = (div_start && dcnt_q == 6'(DIV_LATENCY - 1)) || done_inj;

    always_comb begin
        div_quotient  = '0;
        div_remainder = '0;
        if (div_b != 32'd0) begin
            if (div_sign) begin
                div_quotient  = $signed(div_a) / $signed(div_b);
                div_remainder = $signed(div_a) % $signed(div_b);
            end else begin
                div_quotient  = div_a / div_b;
                div_remainder = div_a % div_b;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Issue one divide; hold = FINISH cycles under pipe_stall, mv_cycle = cycle to pulse lo_we.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input int hold, input int mv_cycle);
        int stalls;
        int starts;
        int n;
        stalls = 0;
        starts = 0;
        n      = 0;
        @(posedge clk);
        #1;
        div_req    = 1'b1;
        div_signed = sgn;
        op_a       = a;
        op_b       = b;
        pipe_stall = (hold > 1);
        #1;
        while (stall_req && n < 100) begin
            stalls++;
            if (div_start) starts++;
            if (n == 1) begin
                check({tag, "_div_a"}, div_a, a);
                check({tag, "_div_b"}, div_b, b);
                check({tag, "_div_sign"}, 32'(div_sign), 32'(sgn));
            end
            @(posedge clk);
            #1;
            n++;
            // operands must already be latched, so scramble the inputs
            op_a       = ~a;
            op_b       = ~b;
            div_signed = ~sgn;
            lo_we      = (n == mv_cycle);
            hilo_wdata = 32'h1234;
            #1;
        end
        lo_we = 1'b0;
        check({tag, "_stall_cycles"}, 32'(stalls), 32'd35);
        check({tag, "_start_cycles"}, 32'(starts), 32'd34);
        check({tag, "_lo"}, lo_o, exp_lo);
        check({tag, "_hi"}, hi_o, exp_hi);
        check({tag, "_fin_start"}, 32'(div_start), 32'd0);
        for (int i = 1; i < hold; i++) begin
            @(posedge clk);
            #2;
            check({tag, "_hold_stall"}, 32'(stall_req), 32'd0);
            check({tag, "_hold_start"}, 32'(div_start), 32'd0);
            check({tag, "_hold_lo"}, lo_o, exp_lo);
            check({tag, "_hold_hi"}, hi_o, exp_hi);
        end
        pipe_stall = 1'b0;
        @(posedge clk);
        #1;
        div_req = 1'b0;
        op_a    = '0;
        op_b    = '0;
        #1;
        check({tag, "_idle_stall"}, 32'(stall_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec      = 0;
        n_miss     = 0;
        rst        = 1'b1;
        div_req    = 1'b0;
        div_signed = 1'b0;
        op_a       = '0;
        op_b       = '0;
        flush      = 1'b0;
        pipe_stall = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        hilo_wdata = '0;
        done_inj   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_hi", hi_o, 32'h0);
        check("rst_lo", lo_o, 32'h0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_start", 32'(div_start), 32'd0);
        check("rst_div_a", div_a, 32'h0);
        check("rst_div_b", div_b, 32'h0);
        check("rst_div_sign", 32'(div_sign), 32'd0);

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1, -1);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1, -1);
        do_div("div_7_m2_hold", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 3, -1);

        // Flush on BUSY cycle 10: no commit, stall released next cycle.
        @(posedge clk);
        #1;
        div_req    = 1'b1;
        div_signed = 1'b0;
        op_a       = 32'd20;
        op_b       = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        #1;
        check("flush_start_low", 32'(div_start), 32'd0);
        check("flush_stall_cycle", 32'(stall_req), 32'd1);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        div_req = 1'b0;
        #1;
        check("flush_stall_after", 32'(stall_req), 32'd0);
        check("flush_lo", lo_o, 32'hFFFF_FFFD);
        check("flush_hi", hi_o, 32'd1);

        // Stale done in IDLE (divider outputs now show 20/3) must not commit.
        @(posedge clk);
        #1;
        done_inj = 1'b1;
        @(posedge clk);
        #1;
        done_inj = 1'b0;
        #1;
        check("stale_done_lo", lo_o, 32'hFFFF_FFFD);
        check("stale_done_hi", hi_o, 32'd1);
        check("stale_done_stall", 32'(stall_req), 32'd0);

        do_div("divu_ffff_16", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'hF, 1, -1);
        do_div("divu_9_4_mtlo", 1'b0, 32'd9, 32'd4, 32'd2, 32'd1, 1, 34);

        // Movers during BUSY, then reset on BUSY cycle 20.
        @(posedge clk);
        #1;
        div_req    = 1'b1;
        div_signed = 1'b0;
        op_a       = 32'd1000;
        op_b       = 32'd3;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            lo_we = (k == 5);
            hi_we = (k == 6);
            hilo_wdata = (k == 5) ? 32'h1234 : 32'hABCD;
            if (k == 20) rst = 1'b1;
            #1;
            if (k == 6) begin
                check("busy_mtlo_lo", lo_o, 32'h1234);
                check("busy_mtlo_hi", hi_o, 32'd1);
            end
            if (k == 7) begin
                check("busy_mthi_hi", hi_o, 32'hABCD);
                check("busy_mthi_lo", lo_o, 32'h1234);
                check("busy_mthi_stall", 32'(stall_req), 32'd1);
            end
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        div_req = 1'b0;
        #1;
        check("midrst_hi", hi_o, 32'h0);
        check("midrst_lo", lo_o, 32'h0);
        check("midrst_stall", 32'(stall_req), 32'd0);
        check("midrst_start", 32'(div_start), 32'd0);

        do_div("divu_50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
